psw_flags_branch_unit: RTL and testbench

- Consumer side of the PSW flag interface.
- Holds the NZVC flags in four JK flip-flops, driven each cycle by the J/K pairs from the flag-computation logic.
- Provides a one-deep shadow PSW that is saved on trap entry and restored on RTI.
- Evaluates branch conditions against the stored flags through a request/response handshake to the control sequencer.

---
 rtl/psw_pkg.sv | 53 +++++
 rtl/branch_cond_eval.sv | 44 ++++
 rtl/psw_flags_branch_unit.sv | 131 +++++++++++++
 tb/tb_psw_flags_branch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psw_pkg.sv
// Shared definitions for the PSW flag / branch unit.
//   - Flag bit positions inside the {N,Z,V,C} word.
//   - Branch condition codes.
//   - Branch handshake FSM state encoding.
//   - JK flip-flop next-state helper.
package psw_pkg;

  localparam int unsigned CondWidth = 4;
  localparam int unsigned PswWidth  = 4;

  localparam int unsigned IDX_N = 3;
  localparam int unsigned IDX_Z = 2;
  localparam int unsigned IDX_V = 1;
  localparam int unsigned IDX_C = 0;

  localparam logic [CondWidth-1:0] COND_BR   = 4'h0;
  localparam logic [CondWidth-1:0] COND_BEQ  = 4'h1;
  localparam logic [CondWidth-1:0] COND_BNE  = 4'h2;
  localparam logic [CondWidth-1:0] COND_BMI  = 4'h3;
  localparam logic [CondWidth-1:0] COND_BPL  = 4'h4;
  localparam logic [CondWidth-1:0] COND_BCS  = 4'h5;
  localparam logic [CondWidth-1:0] COND_BCC  = 4'h6;
  localparam logic [CondWidth-1:0] COND_BVS  = 4'h7;
  localparam logic [CondWidth-1:0] COND_BVC  = 4'h8;
  localparam logic [CondWidth-1:0] COND_BLT  = 4'h9;
  localparam logic [CondWidth-1:0] COND_BGE  = 4'hA;
  localparam logic [CondWidth-1:0] COND_BLE  = 4'hB;
  localparam logic [CondWidth-1:0] COND_BGT  = 4'hC;
  localparam logic [CondWidth-1:0] COND_BHI  = 4'hD;
  localparam logic [CondWidth-1:0] COND_BLS  = 4'hE;
  localparam logic [CondWidth-1:0] COND_RSVD = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
  } br_state_e;

  // Classic JK: 00 hold, 10 set, 01 clear, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    r = q;
    if (j && k) begin
      r = ~q;
    end else if (j) begin
      r = 1'b1;
    end else if (k) begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluator.
//   cond    : condition code
//   psw     : {N,Z,V,C}
//   taken   : condition result (0 for the reserved code)
//   illegal : reserved condition code seen
module branch_cond_eval
  import psw_pkg::*;
(
  input  logic [CondWidth-1:0] cond,
  input  logic [PswWidth-1:0]  psw,
  output logic                 taken,
  output logic                 illegal
);

  logic n, z, v, c;

  always_comb begin
    n       = psw[IDX_N];
    z       = psw[IDX_Z];
    v       = psw[IDX_V];
    c       = psw[IDX_C];
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (cond)
      COND_BR:   taken = 1'b1;
      COND_BEQ:  taken = z;
      COND_BNE:  taken = ~z;
      COND_BMI:  taken = n;
      COND_BPL:  taken = ~n;
      COND_BCS:  taken = c;
      COND_BCC:  taken = ~c;
      COND_BVS:  taken = v;
      COND_BVC:  taken = ~v;
      COND_BLT:  taken = n ^ v;
      COND_BGE:  taken = ~(n ^ v);
      COND_BLE:  taken = z | (n ^ v);
      COND_BGT:  taken = ~(z | (n ^ v));
      COND_BHI:  taken = ~c & ~z;
      COND_BLS:  taken = c | z;
      COND_RSVD: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/psw_flags_branch_unit.sv
// PSW flag register with shadow copy and branch condition handshake.
//   clk, rst            : clock, synchronous active-high reset
//   J_x / K_x           : per-flag JK controls (N, Z, V, C)
//   psw_save            : copy PSW into the shadow (trap entry)
//   psw_restore         : load PSW from the shadow (RTI); overrides JK and save
//   br_req / br_cond    : branch evaluation request, accepted when br_ready=1
//   br_ack              : sequencer consumed the result
//   br_ready            : idle, can accept a request
//   br_valid            : br_taken / br_illegal valid, held until br_ack
//   psw_out             : {N,Z,V,C} register value
//   ctl_err             : one-cycle pulse after simultaneous save and restore
module psw_flags_branch_unit
  import psw_pkg::*;
#(
  parameter int unsigned COND_W = CondWidth,
  parameter int unsigned PSW_W  = PswWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              J_N,
  input  logic              K_N,
  input  logic              J_Z,
  input  logic              K_Z,
  input  logic              J_V,
  input  logic              K_V,
  input  logic              J_C,
  input  logic              K_C,
  input  logic              psw_save,
  input  logic              psw_restore,
  input  logic              br_req,
  input  logic [COND_W-1:0] br_cond,
  input  logic              br_ack,
  output logic              br_ready,
  output logic              br_valid,
  output logic              br_taken,
  output logic              br_illegal,
  output logic [PSW_W-1:0]  psw_out,
  output logic              ctl_err
);

  logic [PSW_W-1:0]  psw_q, psw_d;
  logic [PSW_W-1:0]  shadow_q, shadow_d;
  logic [PSW_W-1:0]  j_vec, k_vec, jk_val;
  logic              ctl_err_q;
  br_state_e         state_q;
  logic [COND_W-1:0] cond_q;
  logic              eval_taken, eval_illegal;

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    j_vec[IDX_N] = J_N;
    j_vec[IDX_Z] = J_Z;
    j_vec[IDX_V] = J_V;
    j_vec[IDX_C] = J_C;
    k_vec[IDX_N] = K_N;
    k_vec[IDX_Z] = K_Z;
    k_vec[IDX_V] = K_V;
    k_vec[IDX_C] = K_C;
    for (int i = 0; i < int'(PSW_W); i++) begin
      jk_val[i] = jk_next(psw_q[i], j_vec[i], k_vec[i]);
    end
    psw_d    = psw_restore ? shadow_q : jk_val;
    // Shadow takes the pre-update PSW; a colliding restore wins and the save is dropped.
    shadow_d = (psw_save && !psw_restore) ? psw_q : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psw_q     <= '0;
      shadow_q  <= '0;
      ctl_err_q <= 1'b0;
    end else begin
      psw_q     <= psw_d;
      shadow_q  <= shadow_d;
      ctl_err_q <= psw_save & psw_restore;
    end
  end

  // Evaluated against next-state PSW so flag updates issued during EVAL are seen;
  // the request-cycle update is already in psw_q by then.
  branch_cond_eval u_eval (
    .cond    (cond_q),
    .psw     (psw_d),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cond_q     <= '0;
      br_ready   <= 1'b1;
      br_valid   <= 1'b0;
      br_taken   <= 1'b0;
      br_illegal <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (br_req) begin
            cond_q   <= br_cond;
            br_ready <= 1'b0;
            state_q  <= StEval;
          end
        end
        StEval: begin
          br_taken   <= eval_taken;
          br_illegal <= eval_illegal;
          br_valid   <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (br_ack) begin
            br_valid <= 1'b0;
            br_ready <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: begin
          br_valid <= 1'b0;
          br_ready <= 1'b1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign psw_out = psw_q;
  assign ctl_err = ctl_err_q;

endmodule

// File: tb/tb_psw_flags_branch_unit.sv
// Self-checking bench for psw_flags_branch_unit: a cycle-level reference model
// checked on every negative edge, plus literal expectations on directed vectors.
module tb_psw_flags_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       J_N, K_N, J_Z, K_Z, J_V, K_V, J_C, K_C;
  logic       psw_save, psw_restore;
  logic       br_req, br_ack;
  logic [3:0] br_cond;
  logic       br_ready, br_valid, br_taken, br_illegal, ctl_err;
  logic [3:0] psw_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psw_flags_branch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .J_N         (J_N),
    .K_N         (K_N),
    .J_Z         (J_Z),
    .K_Z         (K_Z),
    .J_V         (J_V),
    .K_V         (K_V),
    .J_C         (J_C),
    .K_C         (K_C),
    .psw_save    (psw_save),
    .psw_restore (psw_restore),
    .br_req      (br_req),
    .br_cond     (br_cond),
    .br_ack      (br_ack),
    .br_ready    (br_ready),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_illegal  (br_illegal),
    .psw_out     (psw_out),
    .ctl_err     (ctl_err)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_psw, m_shadow, m_cond;
  int         m_phase;  // 0 waiting for request, 1 evaluating, 2 result presented
  logic       m_taken, m_illegal, m_ctl;
  logic       m_live = 1'b0;

  // {taken, illegal} straight from the condition table.
  function automatic logic [1:0] cond_ref(input logic [3:0] c, input logic [3:0] p);
    logic n, z, v, cy;
    n = p[3]; z = p[2]; v = p[1]; cy = p[0];
    case (c)
      4'h0: return 2'b10;
      4'h1: return {z, 1'b0};
      4'h2: return {!z, 1'b0};
      4'h3: return {n, 1'b0};
      4'h4: return {!n, 1'b0};
      4'h5: return {cy, 1'b0};
      4'h6: return {!cy, 1'b0};
      4'h7: return {v, 1'b0};
      4'h8: return {!v, 1'b0};
      4'h9: return {n != v, 1'b0};
      4'hA: return {n == v, 1'b0};
      4'hB: return {z || (n != v), 1'b0};
      4'hC: return {!(z || (n != v)), 1'b0};
      4'hD: return {!cy && !z, 1'b0};
      4'hE: return {cy || z, 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [3:0] psw_after();
    logic [3:0] j, k, r;
    if (psw_restore) return m_shadow;
    j = {J_N, J_Z, J_V, J_C};
    k = {K_N, K_Z, K_V, K_C};
    for (int i = 0; i < 4; i++) begin
      if (j[i] && k[i]) r[i] = !m_psw[i];
      else if (j[i])    r[i] = 1'b1;
      else if (k[i])    r[i] = 1'b0;
      else              r[i] = m_psw[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_psw     <= 4'b0000;
      m_shadow  <= 4'b0000;
      m_phase   <= 0;
      m_cond    <= 4'h0;
      m_taken   <= 1'b0;
      m_illegal <= 1'b0;
      m_ctl     <= 1'b0;
      m_live    <= 1'b1;
    end else begin
      m_psw <= psw_after();
      if (psw_save && !psw_restore) m_shadow <= m_psw;
      m_ctl <= psw_save && psw_restore;
      if (m_phase == 0) begin
        if (br_req) begin
          m_phase <= 1;
          m_cond  <= br_cond;
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
        {m_taken, m_illegal} <= cond_ref(m_cond, psw_after());
      end else if (br_ack) begin
        m_phase <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_psw_out", psw_out, m_psw);
      chk("model_br_ready", {3'b0, br_ready}, {3'b0, m_phase == 0});
      chk("model_br_valid", {3'b0, br_valid}, {3'b0, m_phase == 2});
      chk("model_ctl_err", {3'b0, ctl_err}, {3'b0, m_ctl});
      if (m_phase == 2) begin
        chk("model_br_taken", {3'b0, br_taken}, {3'b0, m_taken});
        chk("model_br_illegal", {3'b0, br_illegal}, {3'b0, m_illegal});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {J_N, K_N, J_Z, K_Z, J_V, K_V, J_C, K_C} = '0;
    psw_save = 1'b0; psw_restore = 1'b0;
    br_req = 1'b0; br_ack = 1'b0; br_cond = 4'h0;
  endtask

  task automatic branch(input logic [3:0] c);
    br_req = 1'b1; br_cond = c;
    cyc();
    clr();
    cyc();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_psw", psw_out, 4'b0000);
    chk("reset_ready", {3'b0, br_ready}, 4'd1);
    chk("reset_valid", {3'b0, br_valid}, 4'd0);
    chk("reset_ctl_err", {3'b0, ctl_err}, 4'd0);

    // JK truth table
    J_N = 1; cyc(); chk("jk_set_n", psw_out, 4'b1000);
    K_N = 1; cyc(); chk("jk_toggle_n", psw_out, 4'b0000);
    clr(); J_Z = 1; K_Z = 1;
    cyc(); chk("jk_toggle_z1", psw_out, 4'b0100);
    cyc(); chk("jk_toggle_z0", psw_out, 4'b0000);
    clr(); J_C = 1; cyc(); chk("jk_set_c", psw_out, 4'b0001);
    clr(); br_ack = 1;  // ack while idle must be ignored
    repeat (5) cyc();
    chk("jk_hold", psw_out, 4'b0001);
    chk("ack_idle_ready", {3'b0, br_ready}, 4'd1);

    // Save captures the pre-update PSW; JK still applies that cycle
    clr(); J_N = 1; J_V = 1; K_C = 1; cyc(); chk("psw_1010", psw_out, 4'b1010);
    clr(); psw_save = 1; K_N = 1; cyc(); chk("save_jk_applies", psw_out, 4'b0010);
    clr(); J_Z = 1; K_V = 1; J_C = 1; cyc(); chk("psw_0101", psw_out, 4'b0101);
    clr(); psw_restore = 1; J_C = 1; cyc(); chk("restore_ignores_jk", psw_out, 4'b1010);

    // Save + restore collision
    clr(); K_N = 1; J_C = 1; cyc(); chk("psw_0011", psw_out, 4'b0011);
    clr(); psw_save = 1; cyc();
    clr(); J_N = 1; J_Z = 1; K_V = 1; K_C = 1; cyc(); chk("psw_1100", psw_out, 4'b1100);
    clr(); psw_save = 1; psw_restore = 1; cyc();
    chk("collide_psw", psw_out, 4'b0011);
    chk("collide_ctl_err", {3'b0, ctl_err}, 4'd1);
    clr(); cyc(); chk("ctl_err_pulse_end", {3'b0, ctl_err}, 4'd0);
    J_N = 1; cyc(); chk("psw_1011", psw_out, 4'b1011);
    clr(); psw_restore = 1; cyc(); chk("shadow_kept_0011", psw_out, 4'b0011);

    // BLT latency and handshake
    clr(); J_N = 1; K_V = 1; cyc(); chk("psw_1001", psw_out, 4'b1001);
    clr(); br_req = 1; br_cond = 4'h9; cyc();
    chk("blt_ready_low", {3'b0, br_ready}, 4'd0);
    chk("blt_valid_low", {3'b0, br_valid}, 4'd0);
    br_cond = 4'hF;  // request held during EVAL is ignored
    cyc();
    chk("blt_valid", {3'b0, br_valid}, 4'd1);
    chk("blt_taken", {3'b0, br_taken}, 4'd1);
    chk("blt_illegal", {3'b0, br_illegal}, 4'd0);
    clr(); J_N = 1; K_N = 1;  // flag changes during RESP must not disturb the result
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("blt_hold_valid", {3'b0, br_valid}, 4'd1);
      chk("blt_hold_taken", {3'b0, br_taken}, 4'd1);
    end
    clr(); br_ack = 1; cyc();
    chk("blt_ack_valid", {3'b0, br_valid}, 4'd0);
    chk("blt_ack_ready", {3'b0, br_ready}, 4'd1);
    chk("psw_0001", psw_out, 4'b0001);

    // Request-cycle flag update is visible: BEQ with J_Z in the same cycle
    clr(); J_Z = 1; branch(4'h1);
    chk("beq_same_cycle", {3'b0, br_taken}, 4'd1);
    br_ack = 1; cyc(); clr();

    // EVAL-cycle flag update is visible: Z cleared while evaluating
    br_req = 1; br_cond = 4'h1; cyc();
    clr(); K_Z = 1; cyc(); clr();
    chk("beq_eval_update", {3'b0, br_taken}, 4'd0);
    br_ack = 1; cyc(); clr();

    // Reserved condition
    branch(4'hF);
    chk("rsvd_taken", {3'b0, br_taken}, 4'd0);
    chk("rsvd_illegal", {3'b0, br_illegal}, 4'd1);

    // Ack held high with a request pending: one IDLE cycle before re-accept
    br_ack = 1; br_req = 1; br_cond = 4'h0; cyc();
    chk("ackhold_idle", {3'b0, br_ready}, 4'd1);
    cyc();
    chk("ackhold_accept", {3'b0, br_ready}, 4'd0);
    br_req = 0; cyc();
    chk("ackhold_valid", {3'b0, br_valid}, 4'd1);
    cyc(); clr();
    chk("ackhold_done", {3'b0, br_ready}, 4'd1);

    // Reset during RESP
    br_req = 1; br_cond = 4'h0; cyc();
    clr(); cyc();
    rst = 1; cyc(); rst = 0;
    chk("rst_mid_valid", {3'b0, br_valid}, 4'd0);
    chk("rst_mid_ready", {3'b0, br_ready}, 4'd1);
    chk("rst_mid_psw", psw_out, 4'b0000);
    J_N = 1; cyc(); clr();
    psw_restore = 1; cyc(); clr();
    chk("rst_shadow_zero", psw_out, 4'b0000);
    branch(4'hE);
    chk("bls_zero", {3'b0, br_taken}, 4'd0);
    br_ack = 1; cyc(); clr();
    branch(4'hD);
    chk("bhi_zero", {3'b0, br_taken}, 4'd1);
    br_ack = 1; cyc(); clr();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
